// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for the two-client ALU arbiter.
// slave is the arbiter's view; master is the surrounding control path plus ALU.
interface alu_arbiter_if;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [1:0]  req0_op;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [1:0]  req1_op;
   logic        resp0_valid, resp0_ready;
   logic        resp1_valid, resp1_ready;
   logic [31:0] resp_data;
   logic        resp_zero, resp_negative, resp_overflow, resp_illegal;
   logic [31:0] alu_a, alu_b;
   logic [1:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero, alu_negative, alu_overflow;
   logic        busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  resp0_ready, resp1_ready,
      input  alu_result, alu_zero, alu_negative, alu_overflow,
      output req0_ready, req1_ready, resp0_valid, resp1_valid,
      output resp_data, resp_zero, resp_negative, resp_overflow, resp_illegal,
      output alu_a, alu_b, alu_op, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output resp0_ready, resp1_ready,
      output alu_result, alu_zero, alu_negative, alu_overflow,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid,
      input  resp_data, resp_zero, resp_negative, resp_overflow, resp_illegal,
      input  alu_a, alu_b, alu_op, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the branch unit (0) and execute unit (1).
// One operation in flight: IDLE accepts, EXEC waits out the ALU latency, RESP holds the result.
module alu_arbiter #(
   parameter int unsigned ALU_LATENCY = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic        illegal_q, illegal_d;
   logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]  alu_op_q, alu_op_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_zero_q, resp_zero_d, resp_negative_q, resp_negative_d;
   logic        resp_overflow_q, resp_overflow_d, resp_illegal_q, resp_illegal_d;
   logic        resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
   logic        busy_q, busy_d;

   logic        sel, accept, resp_taken;
   logic [31:0] sel_a, sel_b;
   logic [1:0]  sel_op;

   always_comb begin
      if (bus.req0_valid && bus.req1_valid) sel = ~last_grant_q;
      else                                  sel = bus.req1_valid;
      accept     = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
      sel_a      = sel ? bus.req1_a  : bus.req0_a;
      sel_b      = sel ? bus.req1_b  : bus.req0_b;
      sel_op     = sel ? bus.req1_op : bus.req0_op;
      resp_taken = owner_q ? bus.resp1_ready : bus.resp0_ready;
   end

   assign bus.req0_ready = accept && !sel;
   assign bus.req1_ready = accept && sel;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      owner_d         = owner_q;
      last_grant_d    = last_grant_q;
      illegal_d       = illegal_q;
      alu_a_d         = alu_a_q;
      alu_b_d         = alu_b_q;
      alu_op_d        = alu_op_q;
      resp_data_d     = resp_data_q;
      resp_zero_d     = resp_zero_q;
      resp_negative_d = resp_negative_q;
      resp_overflow_d = resp_overflow_q;
      resp_illegal_d  = resp_illegal_q;
      resp0_valid_d   = resp0_valid_q;
      resp1_valid_d   = resp1_valid_q;
      busy_d          = busy_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d      = sel;
               last_grant_d = sel;
               busy_d       = 1'b1;
               state_d      = EXEC;
               // Illegal ops leave the ALU untouched but still spend one EXEC cycle,
               // so their response appears one edge after the accept edge.
               if (sel_op == 2'b11) begin
                  illegal_d = 1'b1;
                  cnt_d     = 4'd1;
               end else begin
                  illegal_d = 1'b0;
                  cnt_d     = 4'(ALU_LATENCY + 1);
                  alu_a_d   = sel_a;
                  alu_b_d   = sel_b;
                  alu_op_d  = sel_op;
               end
            end
         end
         EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               if (illegal_q) begin
                  resp_data_d     = '0;
                  resp_zero_d     = 1'b1;
                  resp_negative_d = 1'b0;
                  resp_overflow_d = 1'b0;
                  resp_illegal_d  = 1'b1;
               end else begin
                  resp_data_d     = bus.alu_result;
                  resp_zero_d     = bus.alu_zero;
                  resp_negative_d = bus.alu_negative;
                  resp_overflow_d = (alu_op_q == 2'b01) ? bus.alu_overflow : 1'b0;
                  resp_illegal_d  = 1'b0;
               end
               resp0_valid_d = !owner_q;
               resp1_valid_d = owner_q;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (resp_taken) begin
               resp0_valid_d = 1'b0;
               resp1_valid_d = 1'b0;
               busy_d        = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         owner_q         <= 1'b0;
         last_grant_q    <= 1'b1;
         illegal_q       <= 1'b0;
         alu_a_q         <= '0;
         alu_b_q         <= '0;
         alu_op_q        <= '0;
         resp_data_q     <= '0;
         resp_zero_q     <= 1'b0;
         resp_negative_q <= 1'b0;
         resp_overflow_q <= 1'b0;
         resp_illegal_q  <= 1'b0;
         resp0_valid_q   <= 1'b0;
         resp1_valid_q   <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         owner_q         <= owner_d;
         last_grant_q    <= last_grant_d;
         illegal_q       <= illegal_d;
         alu_a_q         <= alu_a_d;
         alu_b_q         <= alu_b_d;
         alu_op_q        <= alu_op_d;
         resp_data_q     <= resp_data_d;
         resp_zero_q     <= resp_zero_d;
         resp_negative_q <= resp_negative_d;
         resp_overflow_q <= resp_overflow_d;
         resp_illegal_q  <= resp_illegal_d;
         resp0_valid_q   <= resp0_valid_d;
         resp1_valid_q   <= resp1_valid_d;
         busy_q          <= busy_d;
      end
   end

   assign bus.alu_a         = alu_a_q;
   assign bus.alu_b         = alu_b_q;
   assign bus.alu_op        = alu_op_q;
   assign bus.resp_data     = resp_data_q;
   assign bus.resp_zero     = resp_zero_q;
   assign bus.resp_negative = resp_negative_q;
   assign bus.resp_overflow = resp_overflow_q;
   assign bus.resp_illegal  = resp_illegal_q;
   assign bus.resp0_valid   = resp0_valid_q;
   assign bus.resp1_valid   = resp1_valid_q;
   assign bus.busy          = busy_q;
endmodule
